// File: rtl/window_generator_pkg.sv
// Shared helpers for the sliding-window generator:
// counter widths and window element offsets.
package window_generator_pkg;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned pix_off(
    input int unsigned kr,
    input int unsigned kc,
    input int unsigned k,
    input int unsigned pw
  );
    return (kr * k + kc) * pw;
  endfunction

endpackage

// File: rtl/window_generator_row_delay_line.sv
// One image row of pixel history; data_out is the pixel
// shifted in exactly DEPTH accepts ago.
module window_generator_row_delay_line #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clock) begin
    if (shift_en) begin
      sr <= {sr[DEPTH-2:0], data_in};
    end
  end

  assign data_out = sr[DEPTH-1];

endmodule

// File: rtl/window_generator.sv
// Streaming KxK x CHANNELS sliding-window generator with stride.
// Define WINDOW_POS_EN to add registered win_row/win_col outputs.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int ROW_SIZE    = 28,
  parameter int COL_SIZE    = 28,
  parameter int CHANNELS    = 1,
  parameter int STRIDE      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic [CHANNELS*DATA_SIZE-1:0] pixel_data_in,
  input  logic data_in_valid,
  output logic data_in_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_SIZE-1:0] window_out,
  output logic out_valid,
  input  logic out_ready,
  output logic frame_done
`ifdef WINDOW_POS_EN
  ,
  output logic [$clog2(COL_SIZE)-1:0] win_row,
  output logic [$clog2(ROW_SIZE)-1:0] win_col
`endif
);

  localparam int K  = KERNEL_SIZE;
  localparam int PW = CHANNELS * DATA_SIZE;
  localparam int WW = K * K * PW;
  localparam int CW = cnt_w(ROW_SIZE);
  localparam int RW = cnt_w(COL_SIZE);
  localparam int SW = cnt_w(STRIDE);

  localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(COL_SIZE - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);
  localparam logic [SW-1:0] PH_LAST  = SW'(STRIDE - 1);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [SW-1:0] cph_q;
  logic [SW-1:0] rph_q;
  logic [SW-1:0] cph_step;
  logic [SW-1:0] rph_step;
  logic [WW-1:0] win_q;
  logic [WW-1:0] win_d;
  logic          valid_q;
  logic          done_q;
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          complete;
  logic [PW-1:0] tap [K];

  assign data_in_ready = !valid_q || out_ready;
  assign accept   = data_in_valid && data_in_ready;
  assign col_end  = (col_q == COL_LAST);
  assign row_end  = (row_q == ROW_LAST);
  assign cph_step = (cph_q == PH_LAST) ? '0 : cph_q + 1'b1;
  assign rph_step = (rph_q == PH_LAST) ? '0 : rph_q + 1'b1;

  // Phases only advance past the first full window position,
  // so phase zero marks a stride-aligned top-left corner.
  assign complete = (row_q >= ROW_KM1) && (col_q >= COL_KM1) &&
                    (rph_q == '0) && (cph_q == '0);

  // tap[j] is the pixel j rows above the incoming one.
  assign tap[0] = pixel_data_in;

  for (genvar j = 0; j < K - 1; j++) begin : g_line
    window_generator_row_delay_line #(
      .DEPTH (ROW_SIZE),
      .WIDTH (PW)
    ) u_line (
      .clock    (clock),
      .shift_en (accept),
      .data_in  (tap[j]),
      .data_out (tap[j+1])
    );
  end

  always_comb begin
    win_d = win_q;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        if (kc == K - 1) begin
          win_d[pix_off(kr, kc, K, PW) +: PW] = tap[K-1-kr];
        end else begin
          win_d[pix_off(kr, kc, K, PW) +: PW] =
            win_q[pix_off(kr, kc + 1, K, PW) +: PW];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      cph_q   <= '0;
      rph_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= accept && col_end && row_end;
      if (accept) begin
        win_q   <= win_d;
        valid_q <= complete;
        if (col_end) begin
          col_q <= '0;
          cph_q <= '0;
          if (row_end) begin
            row_q <= '0;
            rph_q <= '0;
          end else begin
            row_q <= row_q + 1'b1;
            if (row_q >= ROW_KM1) rph_q <= rph_step;
          end
        end else begin
          col_q <= col_q + 1'b1;
          if (col_q >= COL_KM1) cph_q <= cph_step;
        end
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef WINDOW_POS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      win_row <= '0;
      win_col <= '0;
    end else if (accept && complete) begin
      win_row <= row_q - ROW_KM1;
      win_col <= col_q - COL_KM1;
    end
  end
`endif

  assign window_out = win_q;
  assign out_valid  = valid_q;
  assign frame_done = done_q;

endmodule
